// File: rtl/tx_clk_pkg.sv
// rtl/tx_clk_pkg.sv - shared types and constants for the clock-enable scheduler
package tx_clk_pkg;

    localparam int CNT_W = 5;

    localparam logic [2:0] RATE_DIV1  = 3'd0;
    localparam logic [2:0] RATE_DIV2  = 3'd1;
    localparam logic [2:0] RATE_DIV4  = 3'd2;
    localparam logic [2:0] RATE_DIV8  = 3'd3;
    localparam logic [2:0] RATE_DIV16 = 3'd4;
    localparam logic [2:0] RATE_DIV32 = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Codes 6 and 7 have no divider of their own and clamp to the slowest rate.
    function automatic logic [2:0] sat_rate(input logic [2:0] code);
        return (code > RATE_DIV32) ? RATE_DIV32 : code;
    endfunction

endpackage

// File: rtl/clk_en_sched_if.sv
// rtl/clk_en_sched_if.sv - rate-update handshake bundle
interface clk_en_sched_if;
    logic [2:0] rate_sel;
    logic       rate_vld;
    logic       rate_rdy;

    modport master (output rate_sel, output rate_vld, input  rate_rdy);
    modport slave  (input  rate_sel, input  rate_vld, output rate_rdy);
endinterface

// File: rtl/clk_en_decode.sv
// rtl/clk_en_decode.sv - phase counter to clock-enable strobe decode
module clk_en_decode
    import tx_clk_pkg::*;
(
    input  logic [CNT_W-1:0] cnt,
    input  logic             active,
    output logic             en_2,
    output logic             en_4,
    output logic             en_8,
    output logic             en_16,
    output logic             en_32
);

    // A divide-by-N strobe fires when the low log2(N) phase bits are all ones,
    // so every strobe lines up on the last cycle of the 32-cycle frame.
    always_comb begin
        en_2  = active &   cnt[0];
        en_4  = active & (&cnt[1:0]);
        en_8  = active & (&cnt[2:0]);
        en_16 = active & (&cnt[3:0]);
        en_32 = active & (&cnt[4:0]);
    end

endmodule

// File: rtl/clk_en_sched.sv
// rtl/clk_en_sched.sv - frame-aligned clock-enable scheduler with rate switching
module clk_en_sched
    import tx_clk_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    clk_en_sched_if.slave        rate,
    output logic                 en_2,
    output logic                 en_4,
    output logic                 en_8,
    output logic                 en_16,
    output logic                 en_32,
    output logic                 en_sel,
    output logic                 busy
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       rate_q, rate_d;
    logic [2:0]       pend_q, pend_d;
    logic             active;
    logic             accept;
    logic             frame_end;
    logic [2:0]       req_rate;

    assign active    = (state_q != ST_IDLE);
    assign busy      = active;
    assign rate.rate_rdy = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign accept    = rate.rate_vld && rate.rate_rdy;
    assign frame_end = (cnt_q == {CNT_W{1'b1}});
    assign req_rate  = sat_rate(rate.rate_sel);

    clk_en_decode u_decode (
        .cnt    (cnt_q),
        .active (active),
        .en_2   (en_2),
        .en_4   (en_4),
        .en_8   (en_8),
        .en_16  (en_16),
        .en_32  (en_32)
    );

    // Pick the strobe matching the rate currently in force.
    always_comb begin
        en_sel = 1'b0;
        case (rate_q)
            RATE_DIV1:  en_sel = active;
            RATE_DIV2:  en_sel = en_2;
            RATE_DIV4:  en_sel = en_4;
            RATE_DIV8:  en_sel = en_8;
            RATE_DIV16: en_sel = en_16;
            RATE_DIV32: en_sel = en_32;
            default:    en_sel = 1'b0;
        endcase
    end

    // Next-state logic: rate changes and stops are deferred to the frame boundary.
    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == ST_IDLE) ? '0 : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        rate_d  = rate_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                // Nothing is running, so an accepted rate takes effect at once.
                if (accept) begin
                    rate_d = req_rate;
                    pend_d = req_rate;
                end
                if (start && !stop) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    pend_d = req_rate;
                end
                if (stop) begin
                    state_d = ST_STOP;
                end else if (accept) begin
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                if (stop) begin
                    state_d = ST_STOP;
                end else if (frame_end) begin
                    state_d = ST_RUN;
                    rate_d  = pend_q;
                end
            end
            ST_STOP: begin
                if (frame_end) begin
                    state_d = ST_IDLE;
                    rate_d  = pend_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, phase counter and rate registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rate_q  <= RATE_DIV32;
            pend_q  <= RATE_DIV32;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rate_q  <= rate_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_clk_en_sched.sv
// tb/tb_clk_en_sched.sv - directed self-checking bench for clk_en_sched
module tb_clk_en_sched;

    logic clk;
    logic rst;
    logic start;
    logic stop;
    logic en_2, en_4, en_8, en_16, en_32, en_sel, busy;
    logic [4:0] ens;

    int total;
    int bad;

    clk_en_sched_if rif ();

    clk_en_sched dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stop   (stop),
        .rate   (rif.slave),
        .en_2   (en_2),
        .en_4   (en_4),
        .en_8   (en_8),
        .en_16  (en_16),
        .en_32  (en_32),
        .en_sel (en_sel),
        .busy   (busy)
    );

    assign ens = {en_32, en_16, en_8, en_4, en_2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       stop;
        logic [2:0] rate_sel;
        logic       rate_vld;
        logic       exp_busy;
        logic       exp_rdy;
        logic       exp_en_sel;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] exp_en(input int c);
        logic [4:0] r;
        for (int k = 0; k < 5; k++) begin
            int m;
            m = (2 << k) - 1;
            r[k] = ((c & m) == m);
        end
        return r;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        rif.rate_sel = 3'd0;
        rif.rate_vld = 1'b0;

        tbl[0] = '{1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset state
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_en_sel", en_sel, 0);
        chk("rst_ens", ens, 0);
        chk("rst_rdy", rif.rate_rdy, 1);
        rst = 1'b1;
        step();
        chk("post_rst_ens", ens, 0);
        chk("post_rst_busy", busy, 0);

        // Start at default rate 5
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("r5_busy", busy, 1);
            chk("r5_ens", ens, exp_en(i));
            chk("r5_en_sel", en_sel, (i == 31));
            chk("r5_rdy", rif.rate_rdy, 1);
            step();
        end

        // Rate update to div2 at cnt=10, deferred to the frame boundary
        repeat (10) step();
        chk("upd_rdy_before", rif.rate_rdy, 1);
        rif.rate_sel = 3'd1;
        rif.rate_vld = 1'b1;
        step();
        rif.rate_vld = 1'b0;
        for (int i = 11; i < 32; i++) begin
            chk("sw_rdy", rif.rate_rdy, 0);
            chk("sw_busy", busy, 1);
            chk("sw_en_sel", en_sel, (i == 31));
            step();
        end
        for (int i = 0; i < 32; i++) begin
            chk("r1_en_sel", en_sel, (i % 2 == 1));
            chk("r1_rdy", rif.rate_rdy, 1);
            step();
        end

        // Stop and rate update together at cnt=5
        repeat (5) step();
        stop = 1'b1;
        rif.rate_sel = 3'd3;
        rif.rate_vld = 1'b1;
        step();
        stop = 1'b0;
        rif.rate_vld = 1'b0;
        for (int i = 6; i < 32; i++) begin
            chk("stop_rdy", rif.rate_rdy, 0);
            chk("stop_busy", busy, 1);
            chk("stop_en_sel", en_sel, (i % 2 == 1));
            start = (i == 10);
            step();
        end
        start = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_en_sel", en_sel, 0);
        chk("idle_ens", ens, 0);
        chk("idle_rdy", rif.rate_rdy, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("r3_en_sel", en_sel, (i % 8 == 7));
            step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int i = 1; i < 32; i++) begin
            chk("drain_busy", busy, 1);
            step();
        end
        chk("drain_idle", busy, 0);

        // Table: start&&stop in IDLE, saturated rate, start ignored in STOP
        for (int v = 0; v < 8; v++) begin
            start        = tbl[v].start;
            stop         = tbl[v].stop;
            rif.rate_sel = tbl[v].rate_sel;
            rif.rate_vld = tbl[v].rate_vld;
            step();
            chk($sformatf("vec%0d_busy", v), busy, tbl[v].exp_busy);
            chk($sformatf("vec%0d_rdy", v), rif.rate_rdy, tbl[v].exp_rdy);
            chk($sformatf("vec%0d_en_sel", v), en_sel, tbl[v].exp_en_sel);
        end
        start = 1'b0;
        stop  = 1'b0;
        rif.rate_vld = 1'b0;
        for (int i = 4; i < 32; i++) begin
            chk("sat_en_sel", en_sel, (i == 31));
            chk("sat_ens", ens, exp_en(i));
            step();
        end
        chk("sat_idle", busy, 0);

        // Rate 0 accepted together with start
        rif.rate_sel = 3'd0;
        rif.rate_vld = 1'b1;
        start = 1'b1;
        step();
        rif.rate_vld = 1'b0;
        start = 1'b0;
        chk("div1_en_sel_c0", en_sel, 1);
        step();
        step();
        chk("div1_en_sel_c2", en_sel, 1);

        // Reset mid-frame while switching
        rif.rate_sel = 3'd4;
        rif.rate_vld = 1'b1;
        step();
        rif.rate_vld = 1'b0;
        chk("sw2_rdy", rif.rate_rdy, 0);
        repeat (17) step();
        chk("sw2_rdy_c20", rif.rate_rdy, 0);
        chk("sw2_en_sel_c20", en_sel, 1);
        rst = 1'b0;
        #2;
        chk("arst_busy", busy, 0);
        chk("arst_en_sel", en_sel, 0);
        chk("arst_ens", ens, 0);
        chk("arst_rdy", rif.rate_rdy, 1);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("arel_busy", busy, 0);
        chk("arel_ens", ens, 0);
        chk("arel_en_sel", en_sel, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("arst_rate5_en_sel", en_sel, (i == 31));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_en_sched.md
CLK_EN_SCHED -- requirements
Module: clk_en_sched

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start  input  1  start request, sampled in IDLE only.
REQ-004 SHALL have port: stop  input  1  stop request, sampled in RUN/SWITCH only.
REQ-005 SHALL have port: rate_sel  input  3  rate code: 0=div1, 1=div2, 2=div4, 3=div8, 4=div16, 5=div32; 6/7 saturate to 5.
REQ-006 SHALL have port: rate_vld  input  1  rate_sel valid.
REQ-007 SHALL have port: rate_rdy  output  1  rate update accepted when rate_vld&&rate_rdy.
REQ-008 SHALL have ports: en_2, en_4, en_8, en_16, en_32  output  1 each  single-cycle clock-enable strobes.
REQ-009 SHALL have port: en_sel  output  1  strobe at the currently applied rate.
REQ-010 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL hold a 5-bit phase counter cnt; in IDLE cnt=0; in RUN/SWITCH/STOP cnt increments every cycle, wrapping 31->0.
REQ-012 SHALL assert en_N (N=2..32) combinationally, from registered state only, when state!=IDLE and the low log2(N) bits of cnt are all ones; all strobes coincide at cnt=31.
REQ-013 SHALL drive en_sel = 1 every active cycle for rate 0, else en_sel = the en_N matching the applied rate; 0 in IDLE.
REQ-014 SHALL implement states IDLE, RUN, SWITCH, STOP.
REQ-015 IDLE->RUN on start=1 and stop=0; first RUN cycle has cnt=0; start&&stop in IDLE SHALL leave state IDLE.
REQ-016 RUN->SWITCH on accepted rate update; RUN->STOP on stop=1; if both in same cycle, SHALL go STOP with the new rate pending.
REQ-017 SWITCH->RUN at the cycle with cnt=31, loading pending rate so it is effective from cnt=0; stop in SWITCH SHALL go STOP, keeping the pending rate.
REQ-018 STOP->IDLE at the cycle with cnt=31, applying any pending rate; start in STOP SHALL be ignored.
REQ-019 rate_rdy SHALL be 1 in IDLE and RUN, 0 in SWITCH and STOP.
REQ-020 An update accepted in IDLE SHALL be applied on the next edge, with no state change.
REQ-021 Strobes SHALL never be truncated: the 32-cycle frame in progress always completes before a rate change or stop takes effect.

Reset
REQ-022 On rst=0, SHALL asynchronously force state=IDLE, cnt=0, applied rate=5, pending rate=5, all en_* and en_sel=0, busy=0, and rate_rdy=1.
REQ-023 Reset asserted mid-frame SHALL abort immediately; no strobe SHALL appear while rst=0 or in the first cycle after release.

Structure
REQ-024 Shared package tx_clk_pkg SHALL hold the state enum, rate code constants (RATE_DIV1..RATE_DIV32) and CNT_W=5.
REQ-025 Strobe decode (cnt, active -> en_2..en_32) SHALL be one sub-module clk_en_decode; FSM, counter and rate registers stay in clk_en_sched.

Verification
REQ-026 Reset, start=1 for 1 cycle, rate=5 -> busy=1; en_2 high at cnt 1,3,...; en_32 and en_sel high only at cnt=31 (32nd RUN cycle).
REQ-027 In RUN at rate 5, rate_sel=1 with rate_vld at cnt=10 -> rate_rdy drops; en_sel unchanged until cnt=31; from next cnt=1, en_sel pulses every 2 cycles.
REQ-028 In RUN, stop and rate_vld (rate_sel=3) in the same cycle at cnt=5 -> STOP; IDLE after cnt=31; busy=0; restart shows en_sel every 8 cycles.
REQ-029 In IDLE, rate_sel=7 accepted, then start -> behaves as rate 5 (en_sel once per 32 cycles).
REQ-030 rst pulsed low at cnt=20 in SWITCH -> all outputs 0 immediately; state IDLE; applied rate=5; rate_rdy=1.
